// File: rtl/keypad_if.sv
// Keypad matrix bundle: column drive out, row sense in,
// and the debounced key event toward the function adapter.
interface keypad_if;
   logic [3:0] row_in;
   logic [3:0] col_out;
   logic       keydown;
   logic [3:0] key_id;
   logic       key_held;

   modport master (
      input  row_in,
      output col_out,
      output keydown,
      output key_id,
      output key_held
   );

   modport slave (
      output row_in,
      input  col_out,
      input  keydown,
      input  key_id,
      input  key_held
   );
endinterface

// File: rtl/keypad_scanner.sv
// 4x4 active-low keypad scanner with press/release debounce.
// One key is tracked at a time; key_id = 4*column + row.
module keypad_scanner #(
   parameter int SCAN_DIV       = 50000,
   parameter int DEBOUNCE_TICKS = 20
) (
   input  logic     clk,
   input  logic     rst_n,
   keypad_if.master kp
);

   localparam int TW = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
   localparam int DW =
      (DEBOUNCE_TICKS > 1) ? $clog2(DEBOUNCE_TICKS) : 1;
   localparam logic [TW-1:0] TICK_MAX = TW'(SCAN_DIV - 1);
   localparam logic [DW-1:0] DB_MAX = DW'(DEBOUNCE_TICKS - 1);

   typedef enum logic [1:0] {
      SCAN,
      DEBOUNCE,
      PRESSED,
      RELEASE
   } state_t;

   logic [3:0]    r1_q;
   logic [3:0]    rs_q;
   logic [TW-1:0] cnt_q;
   logic          tick;

   state_t        state_q, state_d;
   logic [1:0]    col_q, col_d;
   logic [3:0]    colo_q, colo_d;
   logic [DW-1:0] db_q, db_d;
   logic [1:0]    cc_q, cc_d;
   logic [1:0]    cr_q, cr_d;
   logic          kd_q, kd_d;
   logic [3:0]    id_q, id_d;
   logic          held_q, held_d;

   logic          hit;
   logic [1:0]    low_row;

   // Two-flop synchronizer for the asynchronous row lines
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r1_q <= 4'hF;
         rs_q <= 4'hF;
      end else begin
         r1_q <= kp.row_in;
         rs_q <= r1_q;
      end
   end

   assign tick = (cnt_q == TICK_MAX);

   // Free-running scan tick divider
   always_ff @(posedge clk) begin
      if (!rst_n)    cnt_q <= '0;
      else if (tick) cnt_q <= '0;
      else           cnt_q <= cnt_q + 1'b1;
   end

   assign hit = ~rs_q[cr_q];

   // Lowest-index pressed row wins when several are low
   always_comb begin
      low_row = 2'd0;
      if      (!rs_q[0]) low_row = 2'd0;
      else if (!rs_q[1]) low_row = 2'd1;
      else if (!rs_q[2]) low_row = 2'd2;
      else if (!rs_q[3]) low_row = 2'd3;
   end

   // Scan/debounce next-state and output decisions, tick-paced
   always_comb begin
      state_d = state_q;
      col_d   = col_q;
      db_d    = db_q;
      cc_d    = cc_q;
      cr_d    = cr_q;
      kd_d    = 1'b0;
      id_d    = id_q;
      held_d  = held_q;
      if (tick) begin
         unique case (state_q)
            SCAN: begin
               if (rs_q == 4'hF) begin
                  col_d = col_q + 2'd1;
               end else begin
                  cc_d    = col_q;
                  cr_d    = low_row;
                  db_d    = '0;
                  state_d = DEBOUNCE;
               end
            end
            DEBOUNCE: begin
               if (!hit) begin
                  state_d = SCAN;
                  col_d   = col_q + 2'd1;
               end else if (db_q == DB_MAX) begin
                  state_d = PRESSED;
                  kd_d    = 1'b1;
                  id_d    = {cc_q, cr_q};
                  held_d  = 1'b1;
               end else begin
                  db_d = db_q + 1'b1;
               end
            end
            PRESSED: begin
               if (!hit) begin
                  db_d    = '0;
                  state_d = RELEASE;
               end
            end
            RELEASE: begin
               if (hit) begin
                  state_d = PRESSED;
               end else if (db_q == DB_MAX) begin
                  held_d  = 1'b0;
                  state_d = SCAN;
                  col_d   = col_q + 2'd1;
               end else begin
                  db_d = db_q + 1'b1;
               end
            end
            default: state_d = SCAN;
         endcase
      end
   end

   assign colo_d = ~(4'b0001 << col_d);

   // State and output registers
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= SCAN;
         col_q   <= 2'd0;
         colo_q  <= 4'b1110;
         db_q    <= '0;
         cc_q    <= 2'd0;
         cr_q    <= 2'd0;
         kd_q    <= 1'b0;
         id_q    <= 4'd0;
         held_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         col_q   <= col_d;
         colo_q  <= colo_d;
         db_q    <= db_d;
         cc_q    <= cc_d;
         cr_q    <= cr_d;
         kd_q    <= kd_d;
         id_q    <= id_d;
         held_q  <= held_d;
      end
   end

   assign kp.col_out  = colo_q;
   assign kp.keydown  = kd_q;
   assign kp.key_id   = id_q;
   assign kp.key_held = held_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// Bench for keypad_scanner: a key-matrix model drives rows,
// a run-length behavioural model predicts every output.
module tb_keypad_scanner;

   localparam int SD = 4;
   localparam int DB = 3;

   logic        clk   = 1'b0;
   logic        rst_n = 1'b0;
   logic [15:0] keys  = '0;
   int          tests = 0;
   int          fails = 0;
   int          pulses = 0;

   keypad_if kp();

   keypad_scanner #(
      .SCAN_DIV      (SD),
      .DEBOUNCE_TICKS(DB)
   ) dut (
      .clk  (clk),
      .rst_n(rst_n),
      .kp   (kp)
   );

   always #5 clk = ~clk;

   function automatic logic [3:0] colv(input int c);
      logic [3:0] v;
      v = 4'b0001 << c;
      return ~v;
   endfunction

   // Closed key pulls its row low while its column is driven
   always_comb begin
      kp.row_in = 4'hF;
      for (int c = 0; c < 4; c++)
         for (int r = 0; r < 4; r++)
            if (keys[4*c+r] && kp.col_out[c] == 1'b0)
               kp.row_in[r] = 1'b0;
   end

   // Reference: a key is accepted after DB+1 consecutive
   // low ticks of its row (first one captures it), and let go
   // after DB+1 consecutive high ticks of that row.
   bit         m_valid = 0;
   int         m_n, m_col, m_cc, m_cr, m_run, m_rel;
   bit         m_cand, m_held, m_kd;
   logic [3:0] m_id, m_h1, m_h2;

   always @(posedge clk) begin
      logic [3:0] rs;
      bit tk;
      if (!rst_n) begin
         m_valid = 1;
         m_n = 0; m_col = 0; m_cc = 0; m_cr = 0;
         m_run = 0; m_rel = 0;
         m_cand = 0; m_held = 0; m_kd = 0;
         m_id = 4'd0; m_h1 = 4'hF; m_h2 = 4'hF;
      end else begin
         rs = m_h2;
         m_h2 = m_h1;
         m_h1 = kp.row_in;
         tk = (m_n % SD) == SD - 1;
         m_n++;
         m_kd = 0;
         if (tk) begin
            if (m_held) begin
               if (rs[m_cr]) begin
                  m_rel++;
                  if (m_rel == DB + 1) begin
                     m_held = 0;
                     m_cand = 0;
                     m_col = (m_col + 1) % 4;
                  end
               end else m_rel = 0;
            end else if (m_cand) begin
               if (!rs[m_cr]) begin
                  m_run++;
                  if (m_run == DB) begin
                     m_held = 1;
                     m_kd = 1;
                     m_id = 4'(4 * m_cc + m_cr);
                     m_rel = 0;
                  end
               end else begin
                  m_cand = 0;
                  m_col = (m_col + 1) % 4;
               end
            end else if (rs == 4'hF) begin
               m_col = (m_col + 1) % 4;
            end else begin
               m_cand = 1;
               m_cc = m_col;
               m_run = 0;
               for (int r = 3; r >= 0; r--)
                  if (!rs[r]) m_cr = r;
            end
         end
      end
   end

   // Every-cycle comparison of the DUT against the model
   always @(negedge clk) begin
      if (kp.keydown === 1'b1) pulses++;
      if (m_valid) begin
         tests++;
         if (kp.col_out !== colv(m_col) ||
             kp.keydown !== m_kd ||
             kp.key_id !== m_id ||
             kp.key_held !== m_held) begin
            fails++;
            $display("FAIL model t=%0t got col=%b kd=%b id=%0d held=%b exp col=%b kd=%b id=%0d held=%b",
                     $time, kp.col_out, kp.keydown, kp.key_id,
                     kp.key_held, colv(m_col), m_kd, m_id,
                     m_held);
         end
      end
   end

   task automatic chk(input string nm,
                      input logic [31:0] got,
                      input logic [31:0] exp);
      tests++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
      end
   endtask

   task automatic wait_kd(input string nm);
      int i = 0;
      while (kp.keydown !== 1'b1 && i < 300) begin
         @(negedge clk);
         i++;
      end
      chk(nm, {31'd0, kp.keydown}, 32'd1);
   endtask

   task automatic wait_held(input string nm, input logic v);
      int i = 0;
      while (kp.key_held !== v && i < 300) begin
         @(negedge clk);
         i++;
      end
      chk(nm, {31'd0, kp.key_held}, {31'd0, v});
   endtask

   task automatic wait_col(input string nm, input logic [3:0] v);
      int i = 0;
      while (kp.col_out !== v && i < 300) begin
         @(negedge clk);
         i++;
      end
      chk(nm, {28'd0, kp.col_out}, {28'd0, v});
   endtask

   initial begin
      int k;
      // reset and idle scan
      repeat (2) @(negedge clk);
      chk("rst_col", kp.col_out, 4'b1110);
      chk("rst_kd", kp.keydown, 0);
      chk("rst_id", kp.key_id, 0);
      chk("rst_held", kp.key_held, 0);
      rst_n = 1'b1;
      for (int i = 1; i <= 4; i++) begin
         repeat (SD) @(negedge clk);
         chk("idle_col", kp.col_out, colv(i % 4));
      end

      // clean press of column 2 row 1
      keys[9] = 1'b1;
      wait_kd("press9_kd");
      chk("press9_id", kp.key_id, 9);
      chk("press9_held", kp.key_held, 1);
      chk("press9_col", kp.col_out, 4'b1011);
      repeat (200) @(negedge clk);
      chk("no_repeat", pulses, 1);
      chk("frozen_col", kp.col_out, 4'b1011);
      keys = '0;
      wait_held("release9", 1'b0);

      // press bounce lasting one tick
      wait_col("sync_col2", 4'b1011);
      keys[9] = 1'b1;
      repeat (SD) @(negedge clk);
      keys = '0;
      repeat (SD) @(negedge clk);
      chk("bounce_col", kp.col_out, 4'b0111);
      chk("bounce_held", kp.key_held, 0);
      chk("bounce_pulses", pulses, 1);

      // release bounce then re-press
      keys[9] = 1'b1;
      wait_kd("repress_kd");
      chk("repress_id", kp.key_id, 9);
      repeat (3) @(negedge clk);
      keys = '0;
      repeat (SD) @(negedge clk);
      keys[9] = 1'b1;
      repeat (2 * SD) @(negedge clk);
      chk("rbounce_held", kp.key_held, 1);
      keys = '0;
      wait_held("rbounce_rel", 1'b0);
      chk("rbounce_pulses", pulses, 2);
      keys[15] = 1'b1;
      wait_kd("press15_kd");
      chk("press15_id", kp.key_id, 15);
      keys = '0;
      wait_held("release15", 1'b0);

      // two keys in column 0
      keys[0] = 1'b1;
      keys[2] = 1'b1;
      wait_kd("two_kd");
      chk("two_id", kp.key_id, 0);
      repeat (3) @(negedge clk);
      keys[2] = 1'b0;
      repeat (40) @(negedge clk);
      chk("two_held", kp.key_held, 1);
      chk("two_id2", kp.key_id, 0);
      chk("two_pulses", pulses, 4);

      // reset while pressed
      rst_n = 1'b0;
      @(negedge clk);
      chk("mrst_col", kp.col_out, 4'b1110);
      chk("mrst_held", kp.key_held, 0);
      chk("mrst_id", kp.key_id, 0);
      chk("mrst_kd", kp.keydown, 0);
      rst_n = 1'b1;
      keys = '0;
      repeat (SD) @(negedge clk);
      chk("mrst_scan", kp.col_out, 4'b1101);

      // randomized key activity with occasional resets
      for (int n = 0; n < 150; n++) begin
         k = $urandom_range(0, 9);
         if (k < 3)
            keys = '0;
         else if (k < 8)
            keys = 16'd1 << $urandom_range(0, 15);
         else
            keys = (16'd1 << $urandom_range(0, 15)) |
                   (16'd1 << $urandom_range(0, 15));
         repeat ($urandom_range(1, 60)) @(negedge clk);
         if ($urandom_range(0, 19) == 0) begin
            rst_n = 1'b0;
            @(negedge clk);
            rst_n = 1'b1;
         end
      end
      keys = '0;
      repeat (40) @(negedge clk);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
